// File: rtl/riscv_vec_pkg.sv
// Shared definitions for the vector writeback path: widths, requester
// indices and the holding-entry payload.
package riscv_vec_pkg;

  localparam int DW   = 256;
  localparam int AW   = 5;
  localparam int VLW  = 32;
  localparam int NREG = 32;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LD  = 1'b1;

  typedef struct packed {
    logic [AW-1:0]  waddr;
    logic [DW-1:0]  wdata;
    logic           wvlen;
    logic [VLW-1:0] wvl;
  } hold_t;

endpackage

// File: rtl/riscv_vec_wb_hold.sv
// One-entry writeback holding register; accepts a new entry in the same
// cycle the current one is drained.
module riscv_vec_wb_hold
  import riscv_vec_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  i_enq_val,
  output logic  o_enq_rdy,
  input  hold_t i_enq_data,
  input  logic  i_deq,
  output logic  o_valid,
  output hold_t o_data
);

  logic  r_valid;
  hold_t r_data;
  logic  w_enq;

  assign o_enq_rdy = !r_valid || i_deq;
  assign w_enq     = i_enq_val && o_enq_rdy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
    end else if (w_enq) begin
      r_valid <= 1'b1;
    end else if (i_deq) begin
      r_valid <= 1'b0;
    end
  end

  // Payload needs no reset; it is only observed while r_valid is set.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_data <= i_enq_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/riscv_core_vec_wb_arbiter.sv
// Arbitrates the vector regfile write port between the ALU and load unit,
// round-robin except that same-destination writes retire oldest first.
module riscv_core_vec_wb_arbiter #(
  parameter int DW  = 256,
  parameter int AW  = 5,
  parameter int VLW = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           alu_val,
  output logic           alu_rdy,
  input  logic [AW-1:0]  alu_waddr,
  input  logic [DW-1:0]  alu_wdata,
  input  logic           alu_wvlen,
  input  logic [VLW-1:0] alu_wvl,
  input  logic           ld_val,
  output logic           ld_rdy,
  input  logic [AW-1:0]  ld_waddr,
  input  logic [DW-1:0]  ld_wdata,
  output logic           wen_p,
  output logic [AW-1:0]  waddr_p,
  output logic [DW-1:0]  wdata_p,
  output logic           wvlen_p,
  output logic [VLW-1:0] wvl_p,
  output logic [31:0]    pend_mask,
  output logic           idle
);

  import riscv_vec_pkg::*;

  hold_t w_alu_in, w_ld_in, w_h0, w_h1;
  logic  w_h0_val, w_h1_val;
  logic  w_grant0, w_grant1, w_sel;
  logic  w_alu_hs, w_ld_hs, w_h0_next, w_h1_next;
  logic  r_rr, r_old;

  assign w_alu_in = '{waddr: alu_waddr, wdata: alu_wdata, wvlen: alu_wvlen, wvl: alu_wvl};
  assign w_ld_in  = '{waddr: ld_waddr, wdata: ld_wdata, wvlen: 1'b0, wvl: '0};

  riscv_vec_wb_hold u_h0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_enq_val  (alu_val),
    .o_enq_rdy  (alu_rdy),
    .i_enq_data (w_alu_in),
    .i_deq      (w_grant0),
    .o_valid    (w_h0_val),
    .o_data     (w_h0)
  );

  riscv_vec_wb_hold u_h1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_enq_val  (ld_val),
    .o_enq_rdy  (ld_rdy),
    .i_enq_data (w_ld_in),
    .i_deq      (w_grant1),
    .o_valid    (w_h1_val),
    .o_data     (w_h1)
  );

  // Same destination forces age order so the later write lands last.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    w_sel    = r_rr;
    if (reset_n) begin
      if (w_h0_val && w_h1_val) begin
        w_sel    = (w_h0.waddr == w_h1.waddr) ? r_old : r_rr;
        w_grant0 = (w_sel == REQ_ALU);
        w_grant1 = (w_sel == REQ_LD);
      end else begin
        w_grant0 = w_h0_val;
        w_grant1 = w_h1_val;
      end
    end
  end

  assign w_alu_hs  = alu_val && alu_rdy;
  assign w_ld_hs   = ld_val && ld_rdy;
  assign w_h0_next = w_alu_hs || (w_h0_val && !w_grant0);
  assign w_h1_next = w_ld_hs || (w_h1_val && !w_grant1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rr  <= REQ_ALU;
      r_old <= REQ_ALU;
    end else begin
      if (w_grant0) begin
        r_rr <= REQ_LD;
      end else if (w_grant1) begin
        r_rr <= REQ_ALU;
      end
      if (w_h0_next && w_h1_next) begin
        if (w_alu_hs && w_ld_hs) begin
          r_old <= REQ_ALU;
        end else if (w_alu_hs) begin
          r_old <= REQ_LD;
        end else if (w_ld_hs) begin
          r_old <= REQ_ALU;
        end
      end else if (w_h0_next) begin
        r_old <= REQ_ALU;
      end else if (w_h1_next) begin
        r_old <= REQ_LD;
      end
    end
  end

  // Register 0 is hardwired, so its entries drain without a write strobe.
  always_comb begin
    wen_p   = 1'b0;
    waddr_p = '0;
    wdata_p = '0;
    if (w_grant0) begin
      wen_p   = (w_h0.waddr != '0);
      waddr_p = w_h0.waddr;
      wdata_p = w_h0.wdata;
    end else if (w_grant1) begin
      wen_p   = (w_h1.waddr != '0);
      waddr_p = w_h1.waddr;
      wdata_p = w_h1.wdata;
    end
  end

  assign wvlen_p = w_grant0 && w_h0.wvlen;
  assign wvl_p   = wvlen_p ? w_h0.wvl : '0;

  always_comb begin
    pend_mask = '0;
    if (w_h0_val) begin
      pend_mask[w_h0.waddr] = 1'b1;
    end
    if (w_h1_val) begin
      pend_mask[w_h1.waddr] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  assign idle = !w_h0_val && !w_h1_val;

endmodule

// File: tb/tb_riscv_core_vec_wb_arbiter.sv
// Scoreboard bench for the vector writeback arbiter: directed stimulus pushes
// hand-ordered expected writes, a negedge monitor pops and compares them.
module tb_riscv_core_vec_wb_arbiter;
  import riscv_vec_pkg::*;

  logic           clk;
  logic           reset_n;
  logic           alu_val, alu_rdy, alu_wvlen;
  logic [AW-1:0]  alu_waddr;
  logic [DW-1:0]  alu_wdata;
  logic [VLW-1:0] alu_wvl;
  logic           ld_val, ld_rdy;
  logic [AW-1:0]  ld_waddr;
  logic [DW-1:0]  ld_wdata;
  logic           wen_p, wvlen_p, idle;
  logic [AW-1:0]  waddr_p;
  logic [DW-1:0]  wdata_p;
  logic [VLW-1:0] wvl_p;
  logic [31:0]    pend_mask;

  typedef struct {
    logic           wen;
    logic [AW-1:0]  waddr;
    logic [DW-1:0]  wdata;
    logic           wvlen;
    logic [VLW-1:0] wvl;
  } exp_t;

  exp_t        expQ[$];
  logic [DW-1:0] rf [32];
  int          checks = 0;
  int          errors = 0;

  riscv_core_vec_wb_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .alu_val   (alu_val),
    .alu_rdy   (alu_rdy),
    .alu_waddr (alu_waddr),
    .alu_wdata (alu_wdata),
    .alu_wvlen (alu_wvlen),
    .alu_wvl   (alu_wvl),
    .ld_val    (ld_val),
    .ld_rdy    (ld_rdy),
    .ld_waddr  (ld_waddr),
    .ld_wdata  (ld_wdata),
    .wen_p     (wen_p),
    .waddr_p   (waddr_p),
    .wdata_p   (wdata_p),
    .wvlen_p   (wvlen_p),
    .wvl_p     (wvl_p),
    .pend_mask (pend_mask),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fill(input logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic vlen, input logic [VLW-1:0] vl);
    exp_t e;
    e.wen = wen; e.waddr = a; e.wdata = d; e.wvlen = vlen; e.wvl = vl;
    expQ.push_back(e);
  endtask

  // Holds the request until it is accepted at a rising edge; returns 1 ns after that edge.
  task automatic applyStimulus(input bit isLd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic vlen, input logic [VLW-1:0] vl);
    bit hs = 1'b0;
    if (isLd) begin
      ld_val = 1'b1; ld_waddr = a; ld_wdata = d;
    end else begin
      alu_val = 1'b1; alu_waddr = a; alu_wdata = d; alu_wvlen = vlen; alu_wvl = vl;
    end
    for (int k = 0; k < 40 && !hs; k++) begin
      @(negedge clk);
      hs = isLd ? ld_rdy : alu_rdy;
      @(posedge clk);
      #1;
    end
    if (isLd) ld_val = 1'b0;
    else alu_val = 1'b0;
    checks++;
    if (!hs) begin
      errors++;
      $display("[TB] FAIL handshake_timeout: got rdy 0 expected 1 (isLd=%0d addr=%0d)", isLd, a);
    end
  endtask

  task automatic waitIdle(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (idle && expQ.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s: got idle %0d pending %0d expected idle 1 pending 0", name, idle, expQ.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write-port strobe must match the next expected write.
  always @(negedge clk) begin
    if (wen_p || wvlen_p) begin
      if (wen_p) rf[waddr_p] = wdata_p;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr %0d wen %0d wvlen %0d expected no write",
                 waddr_p, wen_p, wvlen_p);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("wb_wen", wen_p, e.wen);
        checkOutput("wb_waddr", waddr_p, e.waddr);
        checkOutput("wb_wdata", wdata_p, e.wdata);
        checkOutput("wb_wvlen", wvlen_p, e.wvlen);
        checkOutput("wb_wvl", wvl_p, e.wvl);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    alu_val = 1'b0; alu_waddr = '0; alu_wdata = '0; alu_wvlen = 1'b0; alu_wvl = '0;
    ld_val = 1'b0; ld_waddr = '0; ld_wdata = '0;

    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_idle", idle, 1);
    checkOutput("rst_alu_rdy", alu_rdy, 1);
    checkOutput("rst_ld_rdy", ld_rdy, 1);
    checkOutput("rst_wen", wen_p, 0);
    checkOutput("rst_wvlen", wvlen_p, 0);
    checkOutput("rst_pend", pend_mask, 0);
    checkOutput("rst_waddr", waddr_p, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single ALU write to v3
    pushExp(1'b1, 5'd3, fill(8'hA5), 1'b0, '0);
    applyStimulus(1'b0, 5'd3, fill(8'hA5), 1'b0, '0);
    @(negedge clk);
    checkOutput("t1_pend", pend_mask, 32'h8);
    checkOutput("t1_busy", idle, 0);
    @(negedge clk);
    checkOutput("t1_pend_clear", pend_mask, 0);
    checkOutput("t1_idle", idle, 1);
    waitIdle("t1_drain");

    // Register 0 with vector-length write
    pushExp(1'b0, 5'd0, fill(8'h12), 1'b1, 32'd6);
    applyStimulus(1'b0, 5'd0, fill(8'h12), 1'b1, 32'd6);
    @(negedge clk);
    checkOutput("r0_pend", pend_mask, 0);
    checkOutput("r0_busy", idle, 0);
    waitIdle("r0_drain");

    // Reset with both entries held: nothing may be written
    fork
      applyStimulus(1'b0, 5'd10, fill(8'h0A), 1'b0, '0);
      applyStimulus(1'b1, 5'd11, fill(8'h0B), 1'b0, '0);
    join
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_wen", wen_p, 0);
    checkOutput("mid_rst_held", pend_mask, 32'h0000_0C00);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_idle", idle, 1);
    checkOutput("mid_rst_pend", pend_mask, 0);
    checkOutput("mid_rst_alu_rdy", alu_rdy, 1);
    checkOutput("mid_rst_ld_rdy", ld_rdy, 1);
    @(posedge clk);
    #1;

    // Contention, different addresses: rr restarts at ALU after reset
    for (int k = 0; k < 3; k++) begin
      pushExp(1'b1, 5'd4, fill(8'h40 + 8'(k)), 1'b0, '0);
      pushExp(1'b1, 5'd5, fill(8'h50 + 8'(k)), 1'b0, '0);
    end
    fork
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 5'd4, fill(8'h40 + 8'(k)), 1'b0, '0);
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 5'd5, fill(8'h50 + 8'(k)), 1'b0, '0);
      begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("cont_alu_rdy0", alu_rdy, 1);
        checkOutput("cont_ld_rdy0", ld_rdy, 0);
        @(negedge clk);
        checkOutput("cont_alu_rdy1", alu_rdy, 0);
        checkOutput("cont_ld_rdy1", ld_rdy, 1);
      end
    join
    waitIdle("cont_drain");

    // WAW: load v7 held while ALU v9 drains, then ALU v7 arrives
    pushExp(1'b1, 5'd9, fill(8'h90), 1'b0, '0);
    pushExp(1'b1, 5'd7, fill(8'h71), 1'b0, '0);
    pushExp(1'b1, 5'd7, fill(8'h72), 1'b0, '0);
    fork
      begin
        applyStimulus(1'b0, 5'd9, fill(8'h90), 1'b0, '0);
        applyStimulus(1'b0, 5'd7, fill(8'h72), 1'b0, '0);
      end
      applyStimulus(1'b1, 5'd7, fill(8'h71), 1'b0, '0);
    join
    waitIdle("waw_drain");
    checkOutput("waw_final", rf[7], fill(8'h72));

    // Same-edge same-address: ALU counts as older even though rr favours load
    pushExp(1'b1, 5'd6, fill(8'h61), 1'b1, 32'd3);
    pushExp(1'b1, 5'd6, fill(8'h62), 1'b0, '0);
    fork
      applyStimulus(1'b0, 5'd6, fill(8'h61), 1'b1, 32'd3);
      applyStimulus(1'b1, 5'd6, fill(8'h62), 1'b0, '0);
    join
    waitIdle("same_edge_drain");
    checkOutput("same_edge_final", rf[6], fill(8'h62));

    // Back-to-back loads to v1..v8
    for (int i = 1; i <= 8; i++) pushExp(1'b1, 5'(i), fill(8'h10 + 8'(i)), 1'b0, '0);
    for (int i = 1; i <= 8; i++) begin
      ld_val = 1'b1; ld_waddr = 5'(i); ld_wdata = fill(8'h10 + 8'(i));
      @(negedge clk);
      checkOutput("b2b_ld_rdy", ld_rdy, 1);
      if (i > 1) begin
        checkOutput("b2b_latency_wen", wen_p, 1);
        checkOutput("b2b_latency_addr", waddr_p, 5'(i - 1));
      end
      @(posedge clk);
      #1;
    end
    ld_val = 1'b0;
    waitIdle("b2b_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
